// File: rtl/pow2_lut_arbiter.sv
// Round-robin arbiter sharing one 2^(f/16) fraction LUT between requesters.
// Two-stage stallable pipeline: S1 {id,frac,exp} -> LUT -> S2 {id,exp,sig}.
module pow2_lut_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int EXP_WIDTH = 8,
    parameter int ID_WIDTH  = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*4-1:0]         req_frac,
    input  logic [NUM_REQ*EXP_WIDTH-1:0] req_exp,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ID_WIDTH-1:0]          out_id,
    output logic [EXP_WIDTH-1:0]         out_exp,
    output logic [8:0]                   out_sig,
    output logic                         busy
);

    localparam logic [ID_WIDTH:0]   NR   = (ID_WIDTH+1)'(NUM_REQ);
    localparam logic [ID_WIDTH-1:0] LAST = ID_WIDTH'(NUM_REQ - 1);

    function automatic logic [7:0] pow2_lut(input logic [3:0] f);
        logic [7:0] r;
        case (f)
            4'd0:  r = 8'h00;
            4'd1:  r = 8'h0B;
            4'd2:  r = 8'h17;
            4'd3:  r = 8'h24;
            4'd4:  r = 8'h30;
            4'd5:  r = 8'h3E;
            4'd6:  r = 8'h4C;
            4'd7:  r = 8'h5B;
            4'd8:  r = 8'h6A;
            4'd9:  r = 8'h7A;
            4'd10: r = 8'h8B;
            4'd11: r = 8'h9C;
            4'd12: r = 8'hAF;
            4'd13: r = 8'hC2;
            4'd14: r = 8'hD6;
            default: r = 8'hEA;
        endcase
        return r;
    endfunction

    logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [ID_WIDTH-1:0]  s1_id_q;
    logic [3:0]           s1_frac_q;
    logic [EXP_WIDTH-1:0] s1_exp_q;
    logic                 s2_valid_q, s2_valid_d;
    logic [ID_WIDTH-1:0]  s2_id_q;
    logic [EXP_WIDTH-1:0] s2_exp_q;
    logic [8:0]           s2_sig_q;

    logic                 s1_adv, s2_adv;
    logic                 grant_found, xfer;
    logic [ID_WIDTH-1:0]  grant_id;
    logic [ID_WIDTH:0]    cand;
    logic [3:0]           sel_frac;
    logic [EXP_WIDTH-1:0] sel_exp;

    assign s2_adv = !s2_valid_q || out_ready;
    assign s1_adv = !s1_valid_q || s2_adv;
    assign xfer   = grant_found && s1_adv && !reset;

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_WIDTH+1)'(k);
            if (cand >= NR) cand = cand - NR;
            if (!grant_found && req_valid[cand[ID_WIDTH-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        sel_frac  = '0;
        sel_exp   = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_WIDTH'(i)) begin
                sel_frac     = req_frac[4*i +: 4];
                sel_exp      = req_exp[EXP_WIDTH*i +: EXP_WIDTH];
                req_ready[i] = xfer;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) ptr_d = (grant_id == LAST) ? '0 : grant_id + ID_WIDTH'(1);
        s1_valid_d = s1_adv ? xfer : s1_valid_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (xfer) begin
            s1_id_q   <= grant_id;
            s1_frac_q <= sel_frac;
            s1_exp_q  <= sel_exp;
        end
        if (s2_adv && s1_valid_q) begin
            s2_id_q  <= s1_id_q;
            s2_exp_q <= s1_exp_q;
            s2_sig_q <= {1'b1, pow2_lut(s1_frac_q)};
        end
    end

    assign out_valid = s2_valid_q;
    assign out_id    = s2_id_q;
    assign out_exp   = s2_exp_q;
    assign out_sig   = s2_sig_q;
    assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_pow2_lut_arbiter.sv
// Bench for pow2_lut_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios pinned with literal expectations.
module tb_pow2_lut_arbiter;

    localparam int N = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [15:0] req_frac = '0;
    logic [31:0] req_exp = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_id;
    logic [7:0]  out_exp;
    logic [8:0]  out_sig;
    logic        busy;

    pow2_lut_arbiter #(.NUM_REQ(4), .EXP_WIDTH(8), .ID_WIDTH(2)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_frac(req_frac), .req_exp(req_exp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_exp(out_exp), .out_sig(out_sig),
        .busy(busy)
    );

    always #5 clock = ~clock;

    logic [7:0] tbl [16] = '{8'h00, 8'h0B, 8'h17, 8'h24, 8'h30, 8'h3E,
                             8'h4C, 8'h5B, 8'h6A, 8'h7A, 8'h8B, 8'h9C,
                             8'hAF, 8'hC2, 8'hD6, 8'hEA};

    typedef struct { int id; int frac; int ex; int t; } item_t;
    typedef struct { int id; int val; int ex; int cyc; } ev_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ptr_m = 0;
    item_t mq[$];
    ev_t gnt_log[$];
    ev_t res_log[$];
    logic [11:0] pend [4][$];
    logic [3:0] xfer_mask = '0;
    int ov_hist[512];
    int busy_hist[512];
    int sig_hist[512];
    int rdy_hist[512];

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    function automatic int ci(input int c);
        return (c < 0) ? 0 : ((c > 511) ? 511 : c);
    endfunction
    function automatic int gid(input int k);
        return (k < gnt_log.size()) ? gnt_log[k].id : -1;
    endfunction
    function automatic int gcy(input int k);
        return (k < gnt_log.size()) ? gnt_log[k].cyc : -1;
    endfunction
    function automatic int rid(input int k);
        return (k < res_log.size()) ? res_log[k].id : -1;
    endfunction
    function automatic int rsig(input int k);
        return (k < res_log.size()) ? res_log[k].val : -1;
    endfunction
    function automatic int rexp(input int k);
        return (k < res_log.size()) ? res_log[k].ex : -1;
    endfunction
    function automatic int rcy(input int k);
        return (k < res_log.size()) ? res_log[k].cyc : -1;
    endfunction

    // Reference model: at most two items in flight, each visible at the
    // output no earlier than two cycles after acceptance, FIFO order.
    always @(negedge clock) begin
        bit exp_ov, can;
        int g, idx, er;
        item_t it;
        exp_ov = (mq.size() > 0) && (cyc >= mq[0].t + 2);
        chk("out_valid", int'(out_valid), exp_ov ? 1 : 0);
        chk("busy", int'(busy), (mq.size() > 0) ? 1 : 0);
        if (exp_ov && out_valid) begin
            chk("out_id", int'(out_id), mq[0].id);
            chk("out_exp", int'(out_exp), mq[0].ex);
            chk("out_sig", int'(out_sig), 256 + int'(tbl[mq[0].frac]));
        end
        can = !reset && (mq.size() < 2 || (exp_ov && out_ready));
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (ptr_m + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        er = (can && g >= 0) ? (1 << g) : 0;
        chk("req_ready", int'(req_ready), er);

        xfer_mask = req_valid & req_ready;
        if (out_valid && out_ready)
            res_log.push_back('{int'(out_id), int'(out_sig), int'(out_exp), cyc});
        for (int i = 0; i < N; i++)
            if (xfer_mask[i]) gnt_log.push_back('{i, 0, 0, cyc});
        ov_hist[ci(cyc)]   = int'(out_valid);
        busy_hist[ci(cyc)] = int'(busy);
        sig_hist[ci(cyc)]  = int'(out_sig);
        rdy_hist[ci(cyc)]  = int'(req_ready);

        if (reset) begin
            mq.delete();
            ptr_m = 0;
        end else begin
            if (exp_ov && out_ready) void'(mq.pop_front());
            if (can && g >= 0) begin
                it.id   = g;
                it.frac = int'(req_frac >> (4 * g)) & 15;
                it.ex   = int'(req_exp >> (8 * g)) & 255;
                it.t    = cyc;
                mq.push_back(it);
                ptr_m = (g + 1) % N;
            end
        end
        cyc++;
    end

    // Requesters: present the head of their queue until it transfers.
    always @(posedge clock) begin
        #2;
        for (int i = 0; i < N; i++) begin
            if (xfer_mask[i] && pend[i].size() > 0) void'(pend[i].pop_front());
            req_valid[i] = (pend[i].size() > 0);
            if (pend[i].size() > 0) begin
                req_frac[4*i +: 4] = pend[i][0][11:8];
                req_exp[8*i +: 8]  = pend[i][0][7:0];
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        gnt_log.delete();
        res_log.delete();
    endtask

    initial begin
        int p, r;
        // Reset with a request already pending, then single request
        pend[0].push_back({4'h8, 8'h05});
        step();
        step();
        reset = 1'b0;
        repeat (6) step();
        chk("rst_ready", rdy_hist[0], 0);
        chk("rst_out_valid", ov_hist[0], 0);
        chk("rst_busy", busy_hist[0], 0);
        chk("single_ngrants", gnt_log.size(), 1);
        chk("single_gid", gid(0), 0);
        chk("single_gcyc", gcy(0), 1);
        chk("single_id", rid(0), 0);
        chk("single_exp", rexp(0), 8'h05);
        chk("single_sig", rsig(0), 9'h16A);
        chk("single_latency", rcy(0) - gcy(0), 2);
        chk("single_busy2", busy_hist[ci(gcy(0) + 2)], 1);
        chk("single_busy3", busy_hist[ci(gcy(0) + 3)], 0);

        // Round-robin fairness, all four held valid
        reset = 1'b1;
        step();
        reset = 1'b0;
        clr();
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < N; i++)
                pend[i].push_back({4'(i * 2 + j), 8'(8'h20 + i * 2 + j)});
        repeat (14) step();
        chk("rr_nres", res_log.size(), 8);
        for (int k = 0; k < 8; k++) begin
            chk("rr_grant", gid(k), k % 4);
            chk("rr_res_id", rid(k), k % 4);
            chk("rr_no_bubble", rcy(k) - rcy(0), k);
        end

        // Wrap and skip: grant 2 leaves ptr at 3
        clr();
        pend[2].push_back({4'h3, 8'h30});
        repeat (4) step();
        pend[1].push_back({4'h5, 8'h31});
        pend[3].push_back({4'h6, 8'h32});
        pend[3].push_back({4'h7, 8'h33});
        repeat (8) step();
        chk("wrap_g0", gid(0), 2);
        chk("wrap_g1", gid(1), 3);
        chk("wrap_g2", gid(2), 1);
        chk("wrap_g3", gid(3), 3);
        chk("wrap_sig3", rsig(3), 9'h15B);

        // Backpressure on requester 2
        clr();
        pend[2].push_back({4'h1, 8'h40});
        pend[2].push_back({4'h2, 8'h41});
        pend[2].push_back({4'hF, 8'h42});
        step();
        step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        repeat (6) step();
        p = (gcy(0) < 0) ? 0 : gcy(0);
        for (int k = 2; k < 5; k++) begin
            chk("bp_hold_valid", ov_hist[ci(p + k)], 1);
            chk("bp_hold_sig", sig_hist[ci(p + k)], 9'h10B);
            chk("bp_ready_low", rdy_hist[ci(p + k)], 0);
        end
        chk("bp_nres", res_log.size(), 3);
        chk("bp_sig0", rsig(0), 9'h10B);
        chk("bp_sig1", rsig(1), 9'h117);
        chk("bp_sig2", rsig(2), 9'h1EA);
        chk("bp_third_grant", gcy(2), p + 5);
        chk("bp_first_out", rcy(0), p + 5);

        // LUT sweep from requester 1
        clr();
        for (int f = 0; f < 16; f++) pend[1].push_back({4'(f), 8'(8'h50 + f)});
        repeat (22) step();
        chk("lut_nres", res_log.size(), 16);
        for (int f = 0; f < 16; f++) begin
            chk("lut_sig", rsig(f), 256 + int'(tbl[f]));
            chk("lut_id", rid(f), 1);
        end
        chk("lut_sig8", rsig(8), 9'h16A);
        chk("lut_sig12", rsig(12), 9'h1AF);

        // Reset mid-flight with both stages full and output stalled
        clr();
        out_ready = 1'b0;
        pend[2].push_back({4'h3, 8'h60});
        pend[2].push_back({4'h4, 8'h61});
        pend[2].push_back({4'h5, 8'h62});
        repeat (4) step();
        r = cyc;
        reset = 1'b1;
        pend[2].delete();
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        clr();
        pend[2].push_back({4'h9, 8'h70});
        pend[3].push_back({4'hA, 8'h71});
        repeat (6) step();
        chk("mid_full_before", busy_hist[ci(r - 1)], 1);
        chk("mid_ov_after", ov_hist[ci(r + 1)], 0);
        chk("mid_busy_after", busy_hist[ci(r + 1)], 0);
        chk("mid_g0", gid(0), 2);
        chk("mid_g0_cyc", gcy(0), r + 1);
        chk("mid_res_id", rid(0), 2);
        chk("mid_res_cyc", rcy(0), r + 3);
        chk("mid_res_sig", rsig(0), 9'h17A);
        chk("mid_g1", gid(1), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
